// File: rtl/mau_load_swc.sv
`default_nettype none
// ============================================================================
//  Module   : mau_load_swc
//  Purpose  : Load memory access unit. Takes one load request at a time from
//             the load execute stage, performs a single AHB-Lite read, then
//             aligns/extends the returned lane and writes it to the regfile.
//             Misaligned addresses, ERROR responses and bus timeouts abort
//             the load with a one-cycle error pulse.
//  Ports    : hclk/hrst          clock, async active-high reset
//             exu_load_*         request: valid, rd, base, offset, size, sext
//             mau_load_busy      high while a load is in flight
//             mau_load_err       one-cycle abort pulse
//             haddr/htrans/hsize/hwrite/hready/hresp/hrdata  AHB-Lite master
//             reg_wen/reg_waddr/reg_wdata                     regfile write
//  Revision : 1.0  initial release
// ============================================================================
module mau_load_swc #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        hclk,
  input  logic        hrst,
  input  logic        exu_load_en,
  input  logic [4:0]  exu_load_rd,
  input  logic [31:0] exu_load_base_addr,
  input  logic [31:0] exu_load_offset,
  input  logic [1:0]  exu_load_size,
  input  logic        exu_load_sext,
  output logic        mau_load_busy,
  output logic        mau_load_err,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic [2:0]  hsize,
  output logic        hwrite,
  input  logic        hready,
  input  logic        hresp,
  input  logic [31:0] hrdata,
  output logic        reg_wen,
  output logic [4:0]  reg_waddr,
  output logic [31:0] reg_wdata
);

  localparam logic [1:0] C_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] C_HTRANS_NONSEQ = 2'b10;

  // Counter only needs to reach TIMEOUT_CYC-1; the edge that would take it
  // to TIMEOUT_CYC instead moves the FSM to ERR.
  localparam int         CW     = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] C_TLIM = CW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
  localparam bit         C_TO_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_WB   = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;

  logic [4:0]    r_rd,       w_rd_nxt;
  logic [1:0]    r_alo,      w_alo_nxt;
  logic [1:0]    r_size,     w_size_nxt;
  logic          r_sext,     w_sext_nxt;
  logic [CW-1:0] r_tcnt,     w_tcnt_nxt;

  logic          r_busy,     w_busy_nxt;
  logic          r_err,      w_err_nxt;
  logic [31:0]   r_haddr,    w_haddr_nxt;
  logic [1:0]    r_htrans,   w_htrans_nxt;
  logic [2:0]    r_hsize,    w_hsize_nxt;
  logic          r_wen,      w_wen_nxt;
  logic [4:0]    r_waddr,    w_waddr_nxt;
  logic [31:0]   r_wdata,    w_wdata_nxt;

  logic [31:0]   w_addr_calc;
  logic          w_misalign;
  logic          w_timeout;
  logic [7:0]    w_lane_b;
  logic [15:0]   w_lane_h;
  logic [31:0]   w_ext;

  // Effective address wraps modulo 2^32.
  assign w_addr_calc = exu_load_base_addr + exu_load_offset;

  always_comb begin
    w_misalign = 1'b0;
    case (exu_load_size)
      2'd0:    w_misalign = 1'b0;
      2'd1:    w_misalign = w_addr_calc[0];
      2'd2:    w_misalign = (w_addr_calc[1:0] != 2'b00);
      default: w_misalign = 1'b1;
    endcase
  end

  // Only meaningful while hready=0; the limit is hit on the edge that samples
  // the TIMEOUT_CYC-th consecutive wait cycle.
  assign w_timeout = C_TO_EN && (r_tcnt == C_TLIM);

  // Lane select and extension from the captured low address bits.
  always_comb begin
    w_lane_b = hrdata[7:0];
    case (r_alo)
      2'd0:    w_lane_b = hrdata[7:0];
      2'd1:    w_lane_b = hrdata[15:8];
      2'd2:    w_lane_b = hrdata[23:16];
      default: w_lane_b = hrdata[31:24];
    endcase
  end

  assign w_lane_h = r_alo[1] ? hrdata[31:16] : hrdata[15:0];

  always_comb begin
    w_ext = hrdata;
    case (r_size)
      2'd0:    w_ext = {{24{r_sext & w_lane_b[7]}}, w_lane_b};
      2'd1:    w_ext = {{16{r_sext & w_lane_h[15]}}, w_lane_h};
      default: w_ext = hrdata;
    endcase
  end

  // Next-state and next-output logic. Every output is computed here and
  // registered below, so all DUT outputs come straight from flops.
  always_comb begin
    w_state_nxt  = r_state;
    w_rd_nxt     = r_rd;
    w_alo_nxt    = r_alo;
    w_size_nxt   = r_size;
    w_sext_nxt   = r_sext;
    w_tcnt_nxt   = '0;
    w_err_nxt    = 1'b0;
    w_haddr_nxt  = r_haddr;
    w_htrans_nxt = C_HTRANS_IDLE;
    w_hsize_nxt  = r_hsize;
    w_wen_nxt    = 1'b0;
    w_waddr_nxt  = r_waddr;
    w_wdata_nxt  = r_wdata;

    case (r_state)
      S_IDLE: begin
        if (exu_load_en) begin
          w_rd_nxt   = exu_load_rd;
          w_alo_nxt  = w_addr_calc[1:0];
          w_size_nxt = exu_load_size;
          w_sext_nxt = exu_load_sext;
          if (w_misalign) begin
            w_state_nxt = S_ERR;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt  = S_ADDR;
            w_htrans_nxt = C_HTRANS_NONSEQ;
            w_haddr_nxt  = w_addr_calc;
            w_hsize_nxt  = {1'b0, exu_load_size};
          end
        end
      end

      S_ADDR: begin
        if (hready) begin
          w_state_nxt = S_DATA;
        end else if (w_timeout) begin
          w_state_nxt = S_ERR;
          w_err_nxt   = 1'b1;
        end else begin
          // Address phase must be held stable while the slave stalls.
          w_htrans_nxt = C_HTRANS_NONSEQ;
          w_tcnt_nxt   = C_TO_EN ? r_tcnt + 1'b1 : '0;
        end
      end

      S_DATA: begin
        if (hready) begin
          if (hresp) begin
            w_state_nxt = S_ERR;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_WB;
            w_wen_nxt   = (r_rd != 5'd0);
            w_waddr_nxt = r_rd;
            w_wdata_nxt = w_ext;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_ERR;
          w_err_nxt   = 1'b1;
        end else begin
          w_tcnt_nxt = C_TO_EN ? r_tcnt + 1'b1 : '0;
        end
      end

      S_WB:    w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      r_state  <= S_IDLE;
      r_rd     <= '0;
      r_alo    <= '0;
      r_size   <= '0;
      r_sext   <= 1'b0;
      r_tcnt   <= '0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_haddr  <= '0;
      r_htrans <= C_HTRANS_IDLE;
      r_hsize  <= '0;
      r_wen    <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd     <= w_rd_nxt;
      r_alo    <= w_alo_nxt;
      r_size   <= w_size_nxt;
      r_sext   <= w_sext_nxt;
      r_tcnt   <= w_tcnt_nxt;
      r_busy   <= w_busy_nxt;
      r_err    <= w_err_nxt;
      r_haddr  <= w_haddr_nxt;
      r_htrans <= w_htrans_nxt;
      r_hsize  <= w_hsize_nxt;
      r_wen    <= w_wen_nxt;
      r_waddr  <= w_waddr_nxt;
      r_wdata  <= w_wdata_nxt;
    end
  end

  assign mau_load_busy = r_busy;
  assign mau_load_err  = r_err;
  assign haddr         = r_haddr;
  assign htrans        = r_htrans;
  assign hsize         = r_hsize;
  assign hwrite        = 1'b0;
  assign reg_wen       = r_wen;
  assign reg_waddr     = r_waddr;
  assign reg_wdata     = r_wdata;

endmodule
`default_nettype wire
